// File: rtl/pcm_soft_volume_pkg.sv
// -----------------------------------------------------------------------------
// pcm_soft_volume_pkg
//   Shared definitions for the stereo soft-volume stage: the unity-gain helper
//   and the sequencing FSM state encoding used by pcm_soft_volume.
// -----------------------------------------------------------------------------
package pcm_soft_volume_pkg;

   // Sequencing states: wait for a frame edge, run the multipliers, publish.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Gain value that represents 1.0 for a GW-bit unsigned gain word.
   function automatic int unity_gain(input int gw);
      return 1 << (gw - 1);
   endfunction

endpackage

// File: rtl/pcm_shiftadd_mul.sv
// -----------------------------------------------------------------------------
// pcm_shiftadd_mul
//   Sequential shift-add multiplier: signed PCM sample x unsigned gain.
//   One gain bit is consumed per clock, LSB first, so a product takes
//   GAIN_WIDTH cycles after start. The published product is the accumulator
//   shifted right by GAIN_WIDTH-1 (floor), i.e. the sample scaled by
//   gain/UNITY.
//
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   start    in   1-cycle pulse: latch data/gain, clear accumulator
//   data     in   signed sample
//   gain     in   unsigned gain
//   product  out  floor(data * gain / 2**(GAIN_WIDTH-1)), signed
//   last     out  high during the cycle the final gain bit is accumulated
// -----------------------------------------------------------------------------
module pcm_shiftadd_mul
   import pcm_soft_volume_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int GAIN_WIDTH = 9
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] data,
   input  logic        [GAIN_WIDTH-1:0] gain,
   output logic signed [DATA_WIDTH-1:0] product,
   output logic                         last
);

   localparam int ACC_W = DATA_WIDTH + GAIN_WIDTH;
   localparam int CNT_W = $clog2(GAIN_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAIN_WIDTH - 1);

   logic signed [ACC_W-1:0]      data_ext;
   logic signed [ACC_W-1:0]      acc;
   logic        [GAIN_WIDTH-1:0] gain_q;
   logic        [CNT_W-1:0]      cnt;
   logic                         busy;

   // NOTE: operand registers are reset along with the accumulator so a reset
   // mid-product can never leak a stale partial result into the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_ext <= '0;
         gain_q   <= '0;
         acc      <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
      end else if (start) begin
         data_ext <= {{GAIN_WIDTH{data[DATA_WIDTH-1]}}, data};
         gain_q   <= gain;
         acc      <= '0;
         cnt      <= '0;
         busy     <= 1'b1;
      end else if (busy) begin
         if (gain_q[cnt]) begin
            acc <= acc + (data_ext <<< cnt);
         end
         if (cnt == CNT_LAST) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign last = busy && (cnt == CNT_LAST);

   // |product| <= |data| because gain <= UNITY, so the slice never overflows.
   assign product = acc[ACC_W-2:GAIN_WIDTH-1];

endmodule

// File: rtl/pcm_soft_volume.sv
// -----------------------------------------------------------------------------
// pcm_soft_volume
//   Stereo digital volume / mute stage fed by the I2S->PCM converter. Each
//   frame (rising edge of the word clock) is scaled by a gain that moves at
//   most GAIN_STEP per frame toward the target, giving pop-free volume and
//   mute transitions. Results appear GAIN_WIDTH+1 MCLK cycles after the frame
//   edge, together with a matching delayed word clock.
//
//   MCLK_I   in   master clock (only clock)
//   NRST_I   in   asynchronous active-low reset
//   WCLK_I   in   word clock; rising edge = new L/R pair valid
//   DATAL_I  in   left sample, signed
//   DATAR_I  in   right sample, signed
//   VOL_I    in   target gain, unsigned, clamps to UNITY
//   MUTE_I   in   1 = target gain 0
//   WCLK_O   out  word clock aligned with DATAx_O
//   DATAL_O  out  scaled left sample
//   DATAR_O  out  scaled right sample
//   MUTED_O  out  muted and gain has reached 0
//   OVR_O    out  sticky: frame edge arrived while a product was in flight
// -----------------------------------------------------------------------------
module pcm_soft_volume
   import pcm_soft_volume_pkg::*;
#(
   parameter int PCM_BIT_WIDTH = 32,
   parameter int GAIN_WIDTH    = 9,
   parameter int GAIN_STEP     = 8
) (
   input  logic                            MCLK_I,
   input  logic                            NRST_I,
   input  logic                            WCLK_I,
   input  logic signed [PCM_BIT_WIDTH-1:0] DATAL_I,
   input  logic signed [PCM_BIT_WIDTH-1:0] DATAR_I,
   input  logic        [GAIN_WIDTH-1:0]    VOL_I,
   input  logic                            MUTE_I,
   output logic                            WCLK_O,
   output logic signed [PCM_BIT_WIDTH-1:0] DATAL_O,
   output logic signed [PCM_BIT_WIDTH-1:0] DATAR_O,
   output logic                            MUTED_O,
   output logic                            OVR_O
);

   localparam int GW = GAIN_WIDTH;
   localparam logic [GW-1:0] UNITY_G = GW'(unity_gain(GAIN_WIDTH));
   localparam logic [GW-1:0] STEP_G  = GW'(GAIN_STEP);
   localparam logic [GW:0]   STEP_W  = (GW + 1)'(GAIN_STEP);

   logic                            w_q, w_qq;
   logic                            fe;
   logic                            start;
   logic [1:0]                      state;
   logic [GW-1:0]                   cur_gain;
   logic [GW-1:0]                   tgt;
   logic [GW-1:0]                   gain_next;
   logic [GW:0]                     up_sum;
   logic [GW:0]                     dn_lim;
   logic [GW:0]                     wdly;
   logic signed [PCM_BIT_WIDTH-1:0] product_l, product_r;
   logic                            last_l, last_r;

   assign fe    = w_q & ~w_qq;
   assign start = fe && (state == ST_IDLE);

   // Sums carry one extra bit so cur+STEP near the top of the range cannot wrap.
   assign up_sum = {1'b0, cur_gain} + STEP_W;
   assign dn_lim = {1'b0, tgt} + STEP_W;

   // NOTE: every combinational output gets a default first, so no path
   // through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      tgt = '0;
      if (!MUTE_I) begin
         tgt = (VOL_I > UNITY_G) ? UNITY_G : VOL_I;
      end
   end

   // One ramp step toward the target, never overshooting it.
   always_comb begin
      gain_next = cur_gain;
      if (cur_gain < tgt) begin
         gain_next = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[GW-1:0];
      end else if (cur_gain > tgt) begin
         gain_next = ({1'b0, cur_gain} <= dn_lim) ? tgt : (cur_gain - STEP_G);
      end
   end

   // Word-clock synchroniser and output word-clock delay line. The delay is
   // taken from w_qq so WCLK_O rises on the very edge the data is published.
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge value of its neighbours.
   always_ff @(posedge MCLK_I or negedge NRST_I) begin
      if (!NRST_I) begin
         w_q  <= 1'b0;
         w_qq <= 1'b0;
         wdly <= '0;
      end else begin
         w_q  <= WCLK_I;
         w_qq <= w_q;
         wdly <= {wdly[GW-1:0], w_qq};
      end
   end

   assign WCLK_O = wdly[GW];

   // Frame sequencing, gain ramp and status flags.
   always_ff @(posedge MCLK_I or negedge NRST_I) begin
      if (!NRST_I) begin
         state    <= ST_IDLE;
         cur_gain <= '0;
         DATAL_O  <= '0;
         DATAR_O  <= '0;
         MUTED_O  <= 1'b0;
         OVR_O    <= 1'b0;
      end else begin
         MUTED_O <= MUTE_I && (cur_gain == '0);
         // A frame edge while busy is dropped; only the flag records it.
         if (fe && (state != ST_IDLE)) begin
            OVR_O <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (fe) begin
                  cur_gain <= gain_next;
                  state    <= ST_MUL;
               end
            end
            ST_MUL: begin
               if (last_l && last_r) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               DATAL_O <= product_l;
               DATAR_O <= product_r;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The freshly ramped gain scales the frame that triggered the ramp step.
   pcm_shiftadd_mul #(
      .DATA_WIDTH (PCM_BIT_WIDTH),
      .GAIN_WIDTH (GAIN_WIDTH)
   ) u_mul_l (
      .clk     (MCLK_I),
      .rst_n   (NRST_I),
      .start   (start),
      .data    (DATAL_I),
      .gain    (gain_next),
      .product (product_l),
      .last    (last_l)
   );

   pcm_shiftadd_mul #(
      .DATA_WIDTH (PCM_BIT_WIDTH),
      .GAIN_WIDTH (GAIN_WIDTH)
   ) u_mul_r (
      .clk     (MCLK_I),
      .rst_n   (NRST_I),
      .start   (start),
      .data    (DATAR_I),
      .gain    (gain_next),
      .product (product_r),
      .last    (last_r)
   );

endmodule
